// File: rtl/paicore_axis_rx_checker_if.sv
// AXI-stream beat channel between the loopback receive path and the checker.
interface paicore_axis_rx_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/paicore_axis_rx_checker.sv
// Checks a looped-back AXI stream against seed+i data with an expected length; verdict one cycle after the last beat.
// Backpressure: tready follows a rotating stall pattern during a run and is held low otherwise.
module paicore_axis_rx_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int STALL_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic [31:0]             exp_len,
  input  logic [STALL_W-1:0]      stall_mask,
  paicore_axis_rx_checker_if.slave s_axis,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [31:0]             beat_cnt,
  output logic [31:0]             err_cnt,
  output logic [31:0]             first_err_idx,
  output logic [DATA_WIDTH-1:0]   first_err_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [31:0]           exp_len_q, exp_len_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           err_cnt_q, err_cnt_d;
  logic [31:0]           first_err_idx_q, first_err_idx_d;
  logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic                  pass_q, pass_d;

  logic                  hs;
  logic                  exp_last;
  logic                  beat_err;
  logic [DATA_WIDTH-1:0] exp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      seed_q           <= '0;
      exp_len_q        <= '0;
      stall_q          <= '0;
      beat_cnt_q       <= '0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      seed_q           <= seed_d;
      exp_len_q        <= exp_len_d;
      stall_q          <= stall_d;
      beat_cnt_q       <= beat_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      pass_q           <= pass_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    exp_len_d        = exp_len_q;
    stall_d          = stall_q;
    beat_cnt_d       = beat_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    pass_d           = pass_q;
    s_axis.tready    = 1'b0;
    hs               = 1'b0;
    beat_err         = 1'b0;
    exp_data         = seed_q + DATA_WIDTH'(beat_cnt_q);
    exp_last         = (beat_cnt_q == exp_len_q - 32'd1);

    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d           = seed;
          exp_len_d        = exp_len;
          // An all-zero pattern would deadlock the run, so it means "never stall".
          stall_d          = (stall_mask == '0) ? '1 : stall_mask;
          beat_cnt_d       = '0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          pass_d           = 1'b0;
          state_d          = (exp_len == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        s_axis.tready = stall_q[0];
        stall_d       = STALL_W'({stall_q[0], stall_q} >> 1);
        hs            = s_axis.tvalid & stall_q[0];
        if (hs) begin
          beat_err   = (s_axis.tdata != exp_data) || (s_axis.tlast != exp_last);
          beat_cnt_d = beat_cnt_q + 32'd1;
          if (beat_err) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
            if (err_cnt_q == '0) begin
              first_err_idx_d  = beat_cnt_q;
              first_err_data_d = s_axis.tdata;
            end
          end
          // Either an early tlast or reaching the expected length closes the run.
          if (s_axis.tlast || exp_last) state_d = DONE;
        end
      end
      DONE: begin
        pass_d  = (err_cnt_q == '0) && (beat_cnt_q == exp_len_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy         = (state_q == RUN);
  assign o_done         = (state_q == DONE);
  assign o_pass         = pass_q;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_paicore_axis_rx_checker.sv
// Directed runs against a per-cycle behavioural model of the stream checker, plus literal end-of-run values.
module tb_paicore_axis_rx_checker;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed;
  logic [31:0]   exp_len;
  logic [SW-1:0] stall_mask;
  logic          o_busy, o_done, o_pass;
  logic [31:0]   beat_cnt, err_cnt, first_err_idx;
  logic [DW-1:0] first_err_data;

  paicore_axis_rx_checker_if #(.DATA_WIDTH(DW)) axis ();

  paicore_axis_rx_checker #(.DATA_WIDTH(DW), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .exp_len(exp_len),
    .stall_mask(stall_mask), .s_axis(axis), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 running, 2 verdict cycle; tready in run cycle k is mask bit k mod SW.
  int          m_phase = 0;
  int          m_k = 0;
  logic [DW-1:0] m_seed = '0;
  logic [31:0] m_len = '0;
  logic [SW-1:0] m_mask = '0;
  logic [31:0] m_beats = '0, m_errs = '0, m_fidx = '0;
  logic [DW-1:0] m_fdata = '0;
  logic        m_pass = 1'b0;

  always @(posedge clk) begin
    logic        rdy, bad, lastx;
    logic [31:0] idx;
    if (rst) begin
      m_phase = 0; m_k = 0; m_beats = '0; m_errs = '0; m_fidx = '0; m_fdata = '0; m_pass = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_seed = seed; m_len = exp_len; m_mask = (stall_mask == '0) ? '1 : stall_mask;
        m_beats = '0; m_errs = '0; m_fidx = '0; m_fdata = '0; m_pass = 1'b0; m_k = 0;
        m_phase = (exp_len == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      rdy = m_mask[m_k % SW];
      m_k++;
      if (axis.tvalid && rdy) begin
        idx = m_beats;
        m_beats = m_beats + 1;
        lastx = (idx == m_len - 1);
        bad = (axis.tdata != m_seed + DW'(idx)) || (axis.tlast != lastx);
        if (bad) begin
          if (m_errs == 0) begin m_fidx = idx; m_fdata = axis.tdata; end
          if (m_errs != 32'hFFFF_FFFF) m_errs = m_errs + 1;
        end
        if (axis.tlast || lastx) m_phase = 2;
      end
    end else begin
      m_pass = (m_errs == 0) && (m_beats == m_len);
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (o_done) done_cnt++;
      chk("tready", axis.tready, (m_phase == 1) ? m_mask[m_k % SW] : 1'b0);
      chk("busy", o_busy, m_phase == 1);
      chk("done", o_done, m_phase == 2);
      chk("pass", o_pass, m_pass);
      chk("beat_cnt", beat_cnt, m_beats);
      chk("err_cnt", err_cnt, m_errs);
      chk("first_err_idx", first_err_idx, m_fidx);
      chk("first_err_data", first_err_data, m_fdata);
    end
  end

  logic [DW-1:0] bd [0:15];
  logic          bl [0:15];

  task automatic fill(input int n, input logic [DW-1:0] base, input int lastpos);
    for (int i = 0; i < n; i++) begin
      bd[i] = base + DW'(i);
      bl[i] = (i == lastpos);
    end
  endtask

  // Returns the number of cycles from the start-sampling edge up to and including the o_done cycle.
  task automatic do_run(input logic [DW-1:0] sd, input int len, input logic [SW-1:0] mk,
                        input int nb, input int poke, output int cyc);
    int  iter;
    int  guard;
    bit  hs;
    iter = 0;
    @(posedge clk); #1;
    start = 1'b1; seed = sd; exp_len = len; stall_mask = mk;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      axis.tvalid = 1'b1; axis.tdata = bd[b]; axis.tlast = bl[b];
      if (b == poke) begin
        start = 1'b1; seed = '0; exp_len = 32'd9; stall_mask = 8'h0F;
      end
      guard = 0; hs = 1'b0;
      while (!hs && guard < 64) begin
        @(negedge clk); hs = axis.tready;
        @(posedge clk); #1;
        start = 1'b0; guard++; iter++;
      end
      if (!hs) chk("hs_timeout", hs, 1'b1);
    end
    axis.tvalid = 1'b0; axis.tlast = 1'b0;
    cyc = iter + 1;
    chk("done_after_last", o_done, 1'b1);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 1'b0);
  endtask

  initial begin
    int cyc;
    int d0;
    rst = 1'b1; start = 1'b0; seed = '0; exp_len = '0; stall_mask = '0;
    axis.tvalid = 1'b0; axis.tdata = '0; axis.tlast = 1'b0;
    repeat (2) @(posedge clk); #1;
    cmp_en = 1'b1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tready", axis.tready, 1'b0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    rst = 1'b0;

    // Clean 4-beat run, continuous ready
    fill(4, 64'h100, 3);
    do_run(64'h100, 4, 8'hFF, 4, -1, cyc);
    chk("t1_cycles", cyc, 5);
    chk("t1_beats", beat_cnt, 32'd4);
    chk("t1_errs", err_cnt, 32'd0);
    chk("t1_pass", o_pass, 1'b1);

    // Corrupted beat 2
    fill(4, 64'h100, 3); bd[2] = 64'hDEAD;
    do_run(64'h100, 4, 8'hFF, 4, -1, cyc);
    chk("t2_errs", err_cnt, 32'd1);
    chk("t2_fidx", first_err_idx, 32'd2);
    chk("t2_fdata", first_err_data, 64'hDEAD);
    chk("t2_pass", o_pass, 1'b0);

    // Early tlast on beat 2 with exp_len 5
    fill(3, 64'h100, 2);
    do_run(64'h100, 5, 8'hFF, 3, -1, cyc);
    chk("t3a_beats", beat_cnt, 32'd3);
    chk("t3a_errs", err_cnt, 32'd1);
    chk("t3a_pass", o_pass, 1'b0);

    // Missing tlast with exp_len 3
    fill(3, 64'h100, -1);
    do_run(64'h100, 3, 8'hFF, 3, -1, cyc);
    chk("t3b_beats", beat_cnt, 32'd3);
    chk("t3b_errs", err_cnt, 32'd1);
    chk("t3b_fidx", first_err_idx, 32'd2);

    // Alternating ready: 8 beats over 15 run cycles plus the done cycle
    fill(8, 64'h200, 7);
    do_run(64'h200, 8, 8'h55, 8, -1, cyc);
    chk("t4_cycles", cyc, 16);
    chk("t4_pass", o_pass, 1'b1);
    chk("t4_beats", beat_cnt, 32'd8);

    // All-zero mask behaves like all-ones
    fill(4, 64'h40, 3);
    do_run(64'h40, 4, 8'h00, 4, -1, cyc);
    chk("t5_cycles", cyc, 5);
    chk("t5_pass", o_pass, 1'b1);

    // Zero-length run: o_done right after the start cycle
    do_run(64'h7, 0, 8'hFF, 0, -1, cyc);
    chk("t6_cycles", cyc, 1);
    chk("t6_pass", o_pass, 1'b1);
    chk("t6_beats", beat_cnt, 32'd0);

    // Start during RUN is ignored
    fill(4, 64'h500, 3);
    do_run(64'h500, 4, 8'hFF, 4, 1, cyc);
    chk("t7_beats", beat_cnt, 32'd4);
    chk("t7_errs", err_cnt, 32'd0);
    chk("t7_pass", o_pass, 1'b1);

    // Seed wraps modulo 2^64
    fill(3, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    do_run(64'hFFFF_FFFF_FFFF_FFFE, 3, 8'hFF, 3, -1, cyc);
    chk("t8_pass", o_pass, 1'b1);

    // Reset after 2 of 4 beats
    fill(4, 64'h300, 3);
    @(posedge clk); #1;
    start = 1'b1; seed = 64'h300; exp_len = 32'd4; stall_mask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    axis.tvalid = 1'b1; axis.tdata = bd[0]; axis.tlast = 1'b0;
    @(posedge clk); #1;
    axis.tdata = bd[1];
    @(posedge clk); #1;
    axis.tvalid = 1'b0;
    chk("t9_pre_beats", beat_cnt, 32'd2);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t9_busy", o_busy, 1'b0);
    chk("t9_beats", beat_cnt, 32'd0);
    chk("t9_tready", axis.tready, 1'b0);
    chk("t9_pass", o_pass, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t9_no_done", done_cnt, d0);

    fill(4, 64'h300, 3);
    do_run(64'h300, 4, 8'hFF, 4, -1, cyc);
    chk("t10_beats", beat_cnt, 32'd4);
    chk("t10_pass", o_pass, 1'b1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
